// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and iteration count for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (mode_i=0) or restoring divide (mode_i=1).
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] work_i,
  input  logic [W-1:0]   operand_i,
  input  logic           mode_i,
  output logic [2*W-1:0] work_o
);

  logic [W-1:0] addend;
  logic [W:0]   sum;
  logic [W:0]   cand;
  logic [W:0]   diff;

  always_comb begin
    addend = work_i[0] ? operand_i : '0;
    sum    = {1'b0, work_i[2*W-1:W]} + {1'b0, addend};
    // Remainder shifted left with the next dividend bit; bit W of diff flags a borrow.
    cand   = work_i[2*W-1:W-1];
    diff   = cand - {1'b0, operand_i};
    if (mode_i) begin
      if (diff[W]) work_o = {cand[W-1:0], work_i[W-2:0], 1'b0};
      else         work_o = {diff[W-1:0], work_i[W-2:0], 1'b1};
    end else begin
      work_o = {sum, work_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall request.
// Optional macro MULDIV_DIVZERO_EARLY_EN: divide-by-zero skips CALC and goes straight to FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_in,
  input  logic [2:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         mf_req_in,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out,
  output logic         busy_out,
  output logic         stall_out,
  output logic         done_out
);

  state_e         state_q;
  logic [5:0]     cnt_q;
  logic [2*W-1:0] work_q;
  logic [W-1:0]   opnd_q;
  logic           div_q;
  logic           neg_q;
  logic           neg_rem_q;
  logic           divzero_q;
  logic [W-1:0]   orig_a_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           busy_q;
  logic           done_q;

  logic [2*W-1:0] work_d;
  logic           op_signed;
  logic           op_div;
  logic           op_divzero;
  logic           early_fixup;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  muldiv_step #(.W(W)) u_step (
    .work_i    (work_q),
    .operand_i (opnd_q),
    .mode_i    (div_q),
    .work_o    (work_d)
  );

  always_comb begin
    op_signed  = (op_in == OP_MULT) || (op_in == OP_DIV);
    op_div     = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    op_divzero = op_div && (b_in == '0);
    mag_a      = (op_signed && a_in[W-1]) ? (~a_in + 1'b1) : a_in;
    mag_b      = (op_signed && b_in[W-1]) ? (~b_in + 1'b1) : b_in;
`ifdef MULDIV_DIVZERO_EARLY_EN
    early_fixup = op_divzero;
`else
    early_fixup = 1'b0;
`endif
  end

  always_comb begin
    prod   = neg_q ? (~work_q + 1'b1) : work_q;
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (divzero_q) begin
      res_hi = orig_a_q;
      res_lo = '1;
    end else if (div_q) begin
      res_hi = neg_rem_q ? (~work_q[2*W-1:W] + 1'b1) : work_q[2*W-1:W];
      res_lo = neg_q     ? (~work_q[W-1:0] + 1'b1)   : work_q[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divzero_q <= 1'b0;
      orig_a_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in && is_muldiv_op(op_in)) begin
            div_q     <= op_div;
            neg_q     <= op_signed && (a_in[W-1] ^ b_in[W-1]);
            neg_rem_q <= op_signed && a_in[W-1];
            divzero_q <= op_divzero;
            orig_a_q  <= a_in;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            if (op_div) begin
              work_q <= {{W{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              work_q <= {{W{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
            if (early_fixup) begin
              state_q <= ST_FIXUP;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CALC;
            end
          end else if (start_in && op_in == OP_MTHI) begin
            hi_q <= a_in;
          end else if (start_in && op_in == OP_MTLO) begin
            lo_q <= a_in;
          end
        end
        ST_CALC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITER_COUNT - 1)) begin
            state_q <= ST_FIXUP;
            done_q  <= 1'b1;
          end
        end
        ST_FIXUP: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign stall_out = busy_q & (start_in | mf_req_in);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [2:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        mf_req_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy_out;
  logic        stall_out;
  logic        done_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .op_in     (op_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .mf_req_in (mf_req_in),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy_out  (busy_out),
    .stall_out (stall_out),
    .done_out  (done_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv, pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin pv = 64'(sa * sb); return pv; end
      3'd1: begin pv = {32'd0, a} * {32'd0, b}; return pv; end
      3'd2, 3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin q = sa / sb; r = sa % sb; end
        else begin q = longint'(a) / longint'(b); r = longint'(a) % longint'(b); end
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
    if (op[2]) return 0;
`ifdef MULDIV_DIVZERO_EARLY_EN
    if (op[1] && b == 0) return 1;
`endif
    return 33;
  endfunction

  task automatic wait_done(output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (busy_out && cycles < 100) begin
      cycles++;
      if (done_out) dones++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc, dn;
    logic [63:0] r;
    @(negedge clk);
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    #1;
    check({tag, "_stall_idle"}, 32'(stall_out), 32'd0);
    @(negedge clk);
    start_in = 1'b0;
    wait_done(cyc, dn);
    check({tag, "_busy"}, 32'(cyc), 32'(exp_busy(op, b)));
    check({tag, "_done"}, 32'(dn), op[2] ? 32'd0 : 32'd1);
    r = model(op, a, b, hi_m, lo_m);
    hi_m = r[63:32];
    lo_m = r[31:0];
    check({tag, "_hi"}, hi_out, hi_m);
    check({tag, "_lo"}, lo_out, lo_m);
  endtask

  initial begin
    int cyc, dn;
    logic [63:0] r;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    reset = 1'b1; start_in = 1'b0; op_in = '0; a_in = '0; b_in = '0; mf_req_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", hi_out, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo_out, 32'h0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_lo_const", lo_out, 32'hFFFF_FFEB);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0);
    run_op("div_zero", 3'd2, 32'hFFFF_FFF0, 32'd0);
    run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
    check("mthi_const", hi_out, 32'h1234_5678);
    run_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0);
    run_op("noop", 3'd6, 32'hDEAD_BEEF, 32'd1);

    // Contention: MFHI request and a second start held from CALC cycle 5.
    @(negedge clk);
    start_in = 1'b1; op_in = 3'd0; a_in = 32'hFFFF_0001; b_in = 32'h0001_0003;
    @(negedge clk);
    start_in = 1'b0;
    repeat (4) @(negedge clk);
    mf_req_in = 1'b1; start_in = 1'b1; op_in = 3'd1; a_in = 32'h0F0F_1234; b_in = 32'h8765_4321;
    #1;
    cyc = 0;
    while (busy_out && cyc < 100) begin
      check("cont_stall_busy", 32'(stall_out), 32'd1);
      cyc++;
      @(negedge clk);
      #1;
    end
    check("cont_busy_cnt", 32'(cyc), 32'd29);
    check("cont_stall_idle", 32'(stall_out), 32'd0);
    r = model(3'd0, 32'hFFFF_0001, 32'h0001_0003, hi_m, lo_m);
    hi_m = r[63:32]; lo_m = r[31:0];
    check("cont_first_hi", hi_out, hi_m);
    check("cont_first_lo", lo_out, lo_m);
    @(negedge clk);
    start_in = 1'b0; mf_req_in = 1'b0;
    check("cont_second_accept", 32'(busy_out), 32'd1);
    wait_done(cyc, dn);
    check("cont_second_busy", 32'(cyc), 32'd33);
    check("cont_second_done", 32'(dn), 32'd1);
    r = model(3'd1, 32'h0F0F_1234, 32'h8765_4321, hi_m, lo_m);
    hi_m = r[63:32]; lo_m = r[31:0];
    check("cont_second_hi", hi_out, hi_m);
    check("cont_second_lo", lo_out, lo_m);

    // Reset in the middle of CALC.
    @(negedge clk);
    start_in = 1'b1; op_in = 3'd2; a_in = 32'd1000; b_in = 32'd7;
    @(negedge clk);
    start_in = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy_out), 32'd0);
    check("rst_mid_hi", hi_out, 32'd0);
    check("rst_mid_lo", lo_out, 32'd0);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    dn = 0;
    repeat (40) begin
      if (done_out) dn++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    run_op("post_rst", 3'd3, 32'hFFFF_FFFF, 32'd10);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO operations and sequences a 32-iteration shift-add or restoring-divide datapath. It raises a stall request to the pipeline controller while an operation is in flight and a new multiply/divide op or a HI/LO read arrives.

## Interface
- W, 32: operand width. The unit is only verified at 32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_in  in  1  operation request from decode, qualified by op_in.
- op_in  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- a_in  in  W  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b_in  in  W  rt operand: multiplier or divisor.
- mf_req_in  in  1  MFHI/MFLO in execute; requests HI/LO.
- hi_out  out  W  HI register. Reset value 0.
- lo_out  out  W  LO register. Reset value 0.
- busy_out  out  1  high when state != IDLE. Reset value 0.
- stall_out  out  1  combinational: busy_out & (start_in | mf_req_in). Reset value 0.
- done_out  out  1  high during the FIXUP cycle. Reset value 0.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE, start_in=1, op in 000-011:
  - Latch operand magnitudes (signed ops take |x|; unsigned ops use x as is).
  - Latch result signs, the original a_in, and a div-zero flag (DIV/DIVU with b_in==0).
  - Clear the 6-bit iteration counter, then go to CALC.
- IDLE, start_in=1, op 100/101: write a_in to HI/LO on that edge. Stay in IDLE; no stall.
- IDLE, op 11x: no effect.
- CALC: one iteration per cycle.
  - Multiply: shift-add over a 64-bit product register.
  - Divide: restoring step, remainder in the upper half, quotient in the lower half.
  - After the 32nd iteration (counter==31), go to FIXUP.
- FIXUP: apply signs, write HI/LO on the edge, then go to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ; HI = product[63:32], LO = product[31:0].
  - Signed divide: the quotient is negative if the signs differ; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps).
  - Divide by zero: HI = original a_in, LO = 0xFFFFFFFF, regardless of signedness.
- start_in while busy: not accepted. Decode holds the op via stall_out; it is accepted on the first IDLE cycle.
- Reset at any state: IDLE, HI=LO=0, counter 0, all outputs 0 on the next edge.

## Timing
- Acceptance edge E (IDLE, start_in=1). CALC occupies cycles E+1 … E+32; FIXUP is cycle E+33.
- HI/LO become valid after edge E+33. busy_out is high for 33 cycles.
- done_out is high for exactly one cycle (FIXUP).
- mf_req_in in FIXUP still stalls; the read is serviced in the following IDLE cycle.
- MTHI/MTLO: single-cycle; visible on hi_out/lo_out after the same edge.
- Back-to-back ops: with start_in held, the next op is accepted on the IDLE cycle directly after FIXUP. This gives 34 cycles per multiply/divide.

## Configuration
- MULDIV_DIVZERO_EARLY_EN defined: DIV/DIVU with b_in==0 goes IDLE→FIXUP directly. busy_out is high for 1 cycle; the result is unchanged.
- Undefined: divide-by-zero takes the full 33-cycle path.

## Structure
- Package muldiv_pkg holds:
  - the op_in encoding constants;
  - the state enum (IDLE, CALC, FIXUP);
  - the iteration count constant (32).
- Sub-module muldiv_step is combinational, one iteration:
  - inputs: the 64-bit working register, the operand, and a mode bit;
  - output: the next working register.
- The top level owns the FSM, counter, sign/fixup logic and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, one done pulse.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF. Busy is 33 cycles without the macro and 1 cycle with MULDIV_DIVZERO_EARLY_EN.
- MTHI 0x12345678 in IDLE → hi_out=0x12345678 next cycle with stall_out=0.
- Contention during MULT:
  - mf_req_in at CALC cycle 5 → stall_out=1 through FIXUP, 0 in IDLE.
  - A second start_in held during the MULT → accepted on the first IDLE cycle.
- reset at CALC cycle 10 → next cycle busy_out=0, HI=LO=0, done_out never pulses; a new op then runs normally.
